// File: rtl/osiris_pipe_pkg.sv
// Shared pipeline definitions: stage occupancy states and the default
// width of the control field carried in the low bits of a stage payload.
package osiris_pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_e;

   localparam int unsigned CTRL_WIDTH_DEF = 4;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: event counter that sticks at all-ones, cleared by rst.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] cnt_q;

   // Count qualifying cycles, holding once the counter is saturated.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (i_inc && (cnt_q != '1)) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register built as a 2-entry skid buffer.
// o_ready depends only on registered state (and rst), never on i_ready.
// Invalid slots present a zeroed control field; data bits hold their value.
// Optional statistics counters: define PIPE_STAGE_REG_STATS_EN.
module pipe_stage_reg
   import osiris_pipe_pkg::*;
#(
   parameter int unsigned PAYLOAD_WIDTH = 104,
   parameter int unsigned CTRL_WIDTH    = CTRL_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [PAYLOAD_WIDTH-1:0] i_payload,
   input  logic                     i_flush,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [PAYLOAD_WIDTH-1:0] o_payload
`ifdef PIPE_STAGE_REG_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]     o_stall_cnt,
   output logic [CNT_WIDTH-1:0]     o_flush_cnt
`endif
);

   stage_state_e             state_q;
   logic [PAYLOAD_WIDTH-1:0] main_q;
   logic [PAYLOAD_WIDTH-1:0] skid_q;
   logic                     in_fire;
   logic                     out_fire;
   logic [CTRL_WIDTH-1:0]    ctrl_out;

   assign o_ready  = (state_q != FULL) && !rst;
   assign o_valid  = (state_q != EMPTY);
   assign in_fire  = i_valid && o_ready;
   assign out_fire = o_valid && i_ready;

   // Bubble slots must never carry asserted write-enable control bits.
   assign ctrl_out  = o_valid ? main_q[CTRL_WIDTH-1:0] : '0;
   assign o_payload = {main_q[PAYLOAD_WIDTH-1:CTRL_WIDTH], ctrl_out};

   // Occupancy FSM with main/skid storage; rst, then flush, take priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else if (i_flush) begin
         state_q <= EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_q  <= i_payload;
                  state_q <= ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= i_payload;
               end else if (in_fire) begin
                  skid_q  <= i_payload;
                  state_q <= FULL;
               end else if (out_fire) begin
                  state_q <= EMPTY;
               end
            end
            FULL: begin
               // o_ready is low here, so the only event is a drain into main.
               if (out_fire) begin
                  main_q  <= skid_q;
                  state_q <= ONE;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

`ifdef PIPE_STAGE_REG_STATS_EN
   logic stall_inc;
   logic flush_inc;

   assign stall_inc = o_valid && !i_ready;
   assign flush_inc = i_flush && (state_q != EMPTY);

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (stall_inc),
      .o_cnt (o_stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (flush_inc),
      .o_cnt (o_flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// Statistics checks are built when PIPE_STAGE_REG_STATS_EN is defined.
module tb_pipe_stage_reg;

   localparam int unsigned PW = 104;
   localparam int unsigned CW = 4;
   localparam int unsigned NW = 4;

   logic          clk;
   logic          rst;
   logic          i_valid;
   logic          o_ready;
   logic [PW-1:0] i_payload;
   logic          i_flush;
   logic          o_valid;
   logic          i_ready;
   logic [PW-1:0] o_payload;
`ifdef PIPE_STAGE_REG_STATS_EN
   logic [NW-1:0] o_stall_cnt;
   logic [NW-1:0] o_flush_cnt;
`endif

   int checks;
   int errors;

   pipe_stage_reg #(
      .PAYLOAD_WIDTH (PW),
      .CTRL_WIDTH    (CW),
      .CNT_WIDTH     (NW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_payload   (i_payload),
      .i_flush     (i_flush),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_payload   (o_payload)
`ifdef PIPE_STAGE_REG_STATS_EN
      ,
      .o_stall_cnt (o_stall_cnt),
      .o_flush_cnt (o_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge, then settle so outputs are sampled away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
      i_payload = '0;
      step(); step();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b expected 0", o_valid);
      end
      checks++;
      if (o_payload !== '0) begin
         errors++; $display("FAIL reset_payload: got %h expected 0", o_payload);
      end
      checks++;
      if (o_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready_during: got %b expected 0", o_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (o_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready_after: got %b expected 1", o_ready);
      end
   endtask

   task automatic test_latency();
      i_valid = 1'b1; i_ready = 1'b1; i_payload = PW'(12'hA5F);
      step();
      i_valid = 1'b0;
      checks++;
      if (o_valid !== 1'b1) begin
         errors++; $display("FAIL latency_valid: got %b expected 1", o_valid);
      end
      checks++;
      if (o_payload !== PW'(12'hA5F)) begin
         errors++; $display("FAIL latency_payload: got %h expected a5f", o_payload);
      end
      step();
      // Bubble: control nibble zeroed, data bits held.
      checks++;
      if (o_valid !== 1'b0) begin
         errors++; $display("FAIL bubble_valid: got %b expected 0", o_valid);
      end
      checks++;
      if (o_payload !== PW'(12'hA50)) begin
         errors++; $display("FAIL bubble_payload: got %h expected a50", o_payload);
      end
   endtask

   task automatic test_backpressure();
      i_ready = 1'b0;
      i_valid = 1'b1; i_payload = PW'(12'h111);
      step();
      checks++;
      if (o_ready !== 1'b1) begin
         errors++; $display("FAIL bp_ready_after_a: got %b expected 1", o_ready);
      end
      i_payload = PW'(12'h222);
      step();
      checks++;
      if (o_ready !== 1'b0) begin
         errors++; $display("FAIL bp_ready_after_b: got %b expected 0", o_ready);
      end
      i_payload = PW'(12'h333);
      step();
      checks++;
      if (o_payload !== PW'(12'h111) || o_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold_a: got v=%b %h expected v=1 111", o_valid, o_payload);
      end
      i_valid = 1'b0; i_ready = 1'b1;
      step();
      checks++;
      if (o_payload !== PW'(12'h222) || o_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_out_b: got v=%b %h expected v=1 222", o_valid, o_payload);
      end
      step();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++; $display("FAIL bp_no_c: got valid %b expected 0", o_valid);
      end
   endtask

   task automatic test_throughput();
      logic [PW-1:0] exp_w;
      int nout;
      nout = 0;
      i_ready = 1'b1; i_valid = 1'b1;
      i_payload = {PW'(0), 4'h5} | (PW'(0) << 4);
      for (int cyc = 1; cyc <= 100; cyc++) begin
         step();
         if (o_valid === 1'b1) begin
            exp_w = (PW'(nout) << 4) | PW'(4'h5);
            checks++;
            if (o_payload !== exp_w) begin
               errors++;
               $display("FAIL tput_word%0d: got %h expected %h", nout, o_payload, exp_w);
            end
            nout++;
         end
         if (cyc < 100) i_payload = (PW'(cyc) << 4) | PW'(4'h5);
         else           i_valid = 1'b0;
      end
      step();
      checks++;
      if (nout != 100 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL tput_count: got %0d outputs valid=%b expected 100 valid=0", nout, o_valid);
      end
   endtask

   task automatic test_flush();
      i_ready = 1'b0; i_valid = 1'b1;
      i_payload = PW'(12'h77F); step();
      i_payload = PW'(12'h88F); step();
      i_payload = PW'(12'h99F); i_flush = 1'b1;
      step();
      i_flush = 1'b0; i_valid = 1'b0;
      checks++;
      if (o_valid !== 1'b0) begin
         errors++; $display("FAIL flush_valid: got %b expected 0", o_valid);
      end
      checks++;
      if (o_payload[3:0] !== 4'h0) begin
         errors++; $display("FAIL flush_ctrl: got %h expected 0", o_payload[3:0]);
      end
      checks++;
      if (o_ready !== 1'b1) begin
         errors++; $display("FAIL flush_ready: got %b expected 1", o_ready);
      end
      i_ready = 1'b1;
      step();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++; $display("FAIL flush_drop: got valid %b expected 0", o_valid);
      end
   endtask

   task automatic test_reset_mid();
      i_ready = 1'b0; i_valid = 1'b1;
      i_payload = PW'(12'h12F); step();
      i_payload = PW'(12'h34F); step();
      rst = 1'b1;
      step();
      i_valid = 1'b0;
      checks++;
      if (o_valid !== 1'b0 || o_payload !== '0 || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_during: got v=%b r=%b %h expected v=0 r=0 0",
                  o_valid, o_ready, o_payload);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_after: got r=%b v=%b expected r=1 v=0", o_ready, o_valid);
      end
   endtask

`ifdef PIPE_STAGE_REG_STATS_EN
   task automatic test_stats();
      i_ready = 1'b0; i_valid = 1'b1; i_payload = PW'(12'h5A1);
      step();
      i_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (o_stall_cnt !== 4'd5) begin
         errors++; $display("FAIL stall_cnt5: got %0d expected 5", o_stall_cnt);
      end
      for (int i = 0; i < 15; i++) step();
      checks++;
      if (o_stall_cnt !== 4'd15) begin
         errors++; $display("FAIL stall_cnt_sat: got %0d expected 15", o_stall_cnt);
      end
      checks++;
      if (o_flush_cnt !== 4'd0) begin
         errors++; $display("FAIL flush_cnt0: got %0d expected 0", o_flush_cnt);
      end
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      checks++;
      if (o_flush_cnt !== 4'd1) begin
         errors++; $display("FAIL flush_cnt1: got %0d expected 1", o_flush_cnt);
      end
      step();
      checks++;
      if (o_flush_cnt !== 4'd1) begin
         errors++; $display("FAIL flush_cnt_empty: got %0d expected 1", o_flush_cnt);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
      i_payload = '0;
      test_reset();
      test_latency();
      test_backpressure();
      test_throughput();
      test_flush();
      test_reset_mid();
`ifdef PIPE_STAGE_REG_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
